// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder datapath.
// Holds the default operand width and the operand-count type.
package csa_pkg;

    localparam int CSA_DEF_WIDTH = 8;

    typedef logic [1:0] opcnt_t;

    localparam opcnt_t OUT_COUNT_FULL = 2'd3;

endpackage

// File: rtl/csa_operand_loader.sv
// Collects a stream of operands into triples for a carry-save adder.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
//   out_valid/out_ready downstream; num1..num3 registered operands;
//   out_count = real operands in the triple; flush (only with
//   CSA_LOADER_FLUSH_EN) issues a partial triple.
// Build option: define CSA_LOADER_FLUSH_EN to enable the flush port.
module csa_operand_loader
    import csa_pkg::*;
#(
    parameter int N = CSA_DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
`ifdef CSA_LOADER_FLUSH_EN
    input  logic         flush,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] num1,
    output logic [N-1:0] num2,
    output logic [N-1:0] num3,
    output logic [1:0]   out_count
);

    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] s0_q, s0_d;
    logic [N-1:0] s1_q, s1_d;
    logic [N-1:0] n1_q, n1_d;
    logic [N-1:0] n2_q, n2_d;
    logic [N-1:0] n3_q, n3_d;
    opcnt_t       oc_q, oc_d;
    logic         vld_q, vld_d;
    logic         free;
    logic         blocked;
    logic         acc;

`ifdef CSA_LOADER_FLUSH_EN
    logic pend_q, pend_d;
    assign blocked = pend_q;
`else
    assign blocked = 1'b0;
`endif

    // Output slot can take a new triple this cycle.
    assign free     = !vld_q || out_ready;
    assign in_ready = !blocked && ((cnt_q != 2'd2) || free);
    assign acc      = in_valid && in_ready;

    always_comb begin
        cnt_d = cnt_q;
        s0_d  = s0_q;
        s1_d  = s1_q;
        n1_d  = n1_q;
        n2_d  = n2_q;
        n3_d  = n3_q;
        oc_d  = oc_q;
        vld_d = vld_q && !out_ready;
`ifdef CSA_LOADER_FLUSH_EN
        pend_d = pend_q;
`endif
        if (acc) begin
            unique case (cnt_q)
                2'd0: begin
                    s0_d  = in_data;
                    cnt_d = 2'd1;
                end
                2'd1: begin
                    s1_d  = in_data;
                    cnt_d = 2'd2;
                end
                default: begin
                    // in_ready guarantees the output slot is free here.
                    n1_d  = s0_q;
                    n2_d  = s1_q;
                    n3_d  = in_data;
                    oc_d  = OUT_COUNT_FULL;
                    vld_d = 1'b1;
                    cnt_d = 2'd0;
                end
            endcase
        end
`ifdef CSA_LOADER_FLUSH_EN
        // While pending no operand is accepted, so cnt_q is stable.
        if (pend_q && free) begin
            n1_d   = s0_q;
            n2_d   = (cnt_q == 2'd2) ? s1_q : '0;
            n3_d   = '0;
            oc_d   = cnt_q;
            vld_d  = 1'b1;
            cnt_d  = 2'd0;
            pend_d = 1'b0;
        end else if (flush && (cnt_d != 2'd0)) begin
            // cnt_d already includes an operand accepted this cycle.
            pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            s0_q  <= '0;
            s1_q  <= '0;
            n1_q  <= '0;
            n2_q  <= '0;
            n3_q  <= '0;
            oc_q  <= 2'd0;
            vld_q <= 1'b0;
`ifdef CSA_LOADER_FLUSH_EN
            pend_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            n1_q  <= n1_d;
            n2_q  <= n2_d;
            n3_q  <= n3_d;
            oc_q  <= oc_d;
            vld_q <= vld_d;
`ifdef CSA_LOADER_FLUSH_EN
            pend_q <= pend_d;
`endif
        end
    end

    assign out_valid = vld_q;
    assign num1      = n1_q;
    assign num2      = n2_q;
    assign num3      = n3_q;
    assign out_count = oc_q;

endmodule

// File: tb/tb_csa_operand_loader.sv
// Self-checking bench for csa_operand_loader (N=8).
// Directed scenarios followed by randomized traffic against a queue model.
module tb_csa_operand_loader;
    import csa_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] num1, num2, num3;
    logic [1:0] out_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int n;
    } trip_t;

    int    stg[$];
    trip_t outq[$];
    bit    pend;

    csa_operand_loader #(.N(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef CSA_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num1(num1),
        .num2(num2),
        .num3(num3),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sum3();
        return int'(num1) + int'(num2) + int'(num3);
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit v, input int d, input bit r, input bit f);
        bit    exp_rdy, exp_vld, acc, xfer, fr;
        trip_t t;
        in_valid  = v;
        in_data   = d[7:0];
        out_ready = r;
        flush     = f;
        #3;
        exp_vld = (outq.size() > 0);
        exp_rdy = !pend && (stg.size() < 2 || !exp_vld || r);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), int'(exp_vld));
        if (exp_vld) begin
            chk("num1", int'(num1), outq[0].a);
            chk("num2", int'(num2), outq[0].b);
            chk("num3", int'(num3), outq[0].c);
            chk("out_count", int'(out_count), outq[0].n);
        end
        acc  = v && exp_rdy;
        xfer = exp_vld && r;
        fr   = !exp_vld || r;
        if (xfer) void'(outq.pop_front());
        if (pend && fr) begin
            t.a = stg[0];
            t.b = (stg.size() == 2) ? stg[1] : 0;
            t.c = 0;
            t.n = stg.size();
            outq.push_back(t);
            stg.delete();
            pend = 0;
        end
        if (acc) begin
            stg.push_back(d & 255);
            if (stg.size() == 3) begin
                t.a = stg[0];
                t.b = stg[1];
                t.c = stg[2];
                t.n = 3;
                outq.push_back(t);
                stg.delete();
            end
        end
        if (f && stg.size() > 0) pend = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stg.delete();
        outq.delete();
        pend = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        stg.delete();
        outq.delete();
        pend = 0;

        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_num1", int'(num1), 0);
        chk("rst_num2", int'(num2), 0);
        chk("rst_num3", int'(num3), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // 5,7,9 back-to-back
        cyc(1, 5, 1, 0);
        cyc(1, 7, 1, 0);
        chk("pre_valid", int'(out_valid), 0);
        cyc(1, 9, 1, 0);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_num1", int'(num1), 5);
        chk("t1_num2", int'(num2), 7);
        chk("t1_num3", int'(num3), 9);
        chk("t1_count", int'(out_count), 3);
        chk("t1_sum", sum3(), 21);
        cyc(0, 0, 1, 0);
        chk("t1_cleared", int'(out_valid), 0);

        // Backpressure: six operands, ready low
        for (int i = 0; i < 5; i++) cyc(1, 10 + i, 0, 0);
        chk("bp_in_ready", int'(in_ready), 0);
        cyc(1, 15, 0, 0);
        cyc(1, 15, 1, 0);
        chk("bp_no_bubble", int'(out_valid), 1);
        chk("bp_num1", int'(num1), 13);
        chk("bp_num3", int'(num3), 15);
        cyc(0, 0, 1, 0);

        // Max values
        for (int i = 0; i < 3; i++) cyc(1, 255, 1, 0);
        chk("max_num3", int'(num3), 255);
        chk("max_sum", sum3(), 765);
        cyc(0, 0, 1, 0);

        // Reset mid-fill
        cyc(1, 77, 1, 0);
        cyc(1, 88, 1, 0);
        do_reset();
        chk("rst2_valid", int'(out_valid), 0);
        for (int i = 1; i <= 3; i++) cyc(1, i, 0, 0);
        chk("rst2_num1", int'(num1), 1);
        chk("rst2_num2", int'(num2), 2);
        chk("rst2_num3", int'(num3), 3);

        // Transfer coincident with 3rd accept of next triple
        cyc(1, 40, 0, 0);
        cyc(1, 41, 0, 0);
        cyc(1, 42, 1, 0);
        chk("co_valid", int'(out_valid), 1);
        chk("co_num1", int'(num1), 40);
        chk("co_num3", int'(num3), 42);
        cyc(0, 0, 1, 0);

`ifdef CSA_LOADER_FLUSH_EN
        cyc(1, 3, 1, 0);
        cyc(1, 4, 1, 0);
        cyc(0, 0, 1, 1);
        chk("fl_in_ready", int'(in_ready), 0);
        cyc(1, 99, 1, 0);
        chk("fl_valid", int'(out_valid), 1);
        chk("fl_num1", int'(num1), 3);
        chk("fl_num2", int'(num2), 4);
        chk("fl_num3", int'(num3), 0);
        chk("fl_count", int'(out_count), 2);
        cyc(0, 0, 1, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                $urandom_range(0, 2) != 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
